// File: rtl/output_deskew.sv
// Output deskew for the systolic array: lane k is delayed LANES-1-k extra cycles so each row leaves as one aligned beat.
// Optional build macro DESKEW_ZERO_FILL_EN: lanes whose aligned valid bit is low drive zeros on data_out.
module output_deskew #(
   parameter int LANES = 4,
   parameter int DW    = 32,
   parameter int CW    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [LANES-1:0]    in_valid,
   input  logic [LANES*DW-1:0] data_in,
   input  logic                start,
   input  logic [CW-1:0]       row_total,
   output logic [LANES*DW-1:0] data_out,
   output logic                out_valid,
   output logic                done,
   output logic                busy,
   output logic                skew_err,
   output logic [CW-1:0]       row_count
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   logic [LANES*DW-1:0] al_data;
   logic [LANES-1:0]    av;
   logic [LANES*DW-1:0] dout_q, dout_d;
   logic                ovld_q;
   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [CW-1:0]       total_q, total_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                mis;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      localparam int D = LANES - 1 - k;
      logic [DW-1:0] lane_in;
      assign lane_in = data_in[(LANES-k)*DW-1 -: DW];

      if (D == 0) begin : g_direct
         assign al_data[(LANES-k)*DW-1 -: DW] = lane_in;
         assign av[k] = in_valid[k];
      end else begin : g_chain
         logic [DW-1:0] dat_q [D];
         logic [D-1:0]  vld_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < D; i++) dat_q[i] <= '0;
               vld_q <= '0;
            end else begin
               dat_q[0] <= lane_in;
               vld_q[0] <= in_valid[k];
               for (int i = 1; i < D; i++) begin
                  dat_q[i] <= dat_q[i-1];
                  vld_q[i] <= vld_q[i-1];
               end
            end
         end

         assign al_data[(LANES-k)*DW-1 -: DW] = dat_q[D-1];
         assign av[k] = vld_q[D-1];
      end
   end

   always_comb begin
      dout_d = al_data;
`ifdef DESKEW_ZERO_FILL_EN
      for (int k = 0; k < LANES; k++)
         if (!av[k]) dout_d[(LANES-k)*DW-1 -: DW] = '0;
`endif
   end

   // A partially valid aligned vector means the upstream skew was broken for this row.
   assign mis   = (av != '0) && (av != '1);
   assign err_d = start ? 1'b0 : (err_q | mis);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      total_d = total_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (row_total == '0) begin
                  done_d = 1'b1;
               end else begin
                  total_d = row_total;
                  cnt_d   = '0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // A restart takes precedence over a final beat landing in the same cycle.
            if (start) begin
               total_d = row_total;
               cnt_d   = '0;
               if (row_total == '0) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end else if (ovld_q) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_d == total_q) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q  <= '0;
         ovld_q  <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         total_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         dout_q  <= dout_d;
         ovld_q  <= &av;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         total_q <= total_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign data_out  = dout_q;
   assign out_valid = ovld_q;
   assign done      = done_q;
   assign busy      = (state_q == RUN);
   assign skew_err  = err_q;
   assign row_count = cnt_q;

endmodule

// File: tb/tb_output_deskew.sv
// Randomized and directed bench for output_deskew against a history-queue reference model.
module tb_output_deskew;
   localparam int LANES = 4;
   localparam int DW    = 8;
   localparam int CW    = 16;
   localparam int W     = LANES * DW;

   logic             clk = 1'b0;
   logic             rst;
   logic [LANES-1:0] in_valid;
   logic [W-1:0]     data_in;
   logic             start;
   logic [CW-1:0]    row_total;
   logic [W-1:0]     data_out;
   logic             out_valid, done, busy, skew_err;
   logic [CW-1:0]    row_count;

   output_deskew #(.LANES(LANES), .DW(DW), .CW(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
      .start(start), .row_total(row_total), .data_out(data_out),
      .out_valid(out_valid), .done(done), .busy(busy),
      .skew_err(skew_err), .row_count(row_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int n_done = 0;

   // Stimulus generator: entry j holds the row launched j cycles ago.
   logic             g_l [LANES];
   logic [W-1:0]     g_d [LANES];
   logic [LANES-1:0] g_m [LANES];

   // Reference: inputs sampled j edges ago, plus control state.
   logic [LANES-1:0] h_v [LANES];
   logic [W-1:0]     h_d [LANES];
   logic             m_ov, m_done, m_busy, m_err;
   logic [W-1:0]     m_dout;
   int               m_cnt, m_total;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("data_out",  64'(data_out),  64'(m_dout));
      chk("done",      64'(done),      64'(m_done));
      chk("busy",      64'(busy),      64'(m_busy));
      chk("skew_err",  64'(skew_err),  64'(m_err));
      chk("row_count", 64'(row_count), 64'(m_cnt));
      if (done) n_done++;
   endtask

   task automatic model_edge(input bit st, input int tot);
      logic [LANES-1:0] av;
      logic [W-1:0]     ad;
      logic             old_ov;
      old_ov = m_ov;
      for (int j = LANES-1; j > 0; j--) begin
         h_v[j] = h_v[j-1];
         h_d[j] = h_d[j-1];
      end
      h_v[0] = in_valid;
      h_d[0] = data_in;
      for (int k = 0; k < LANES; k++) begin
         av[k] = h_v[LANES-1-k][k];
         ad[(LANES-k)*DW-1 -: DW] = h_d[LANES-1-k][(LANES-k)*DW-1 -: DW];
`ifdef DESKEW_ZERO_FILL_EN
         if (!av[k]) ad[(LANES-k)*DW-1 -: DW] = '0;
`endif
      end
      m_done = 1'b0;
      if (st) begin
         if (tot == 0) begin
            m_done = 1'b1;
            if (m_busy) m_cnt = 0;
            m_busy = 1'b0;
         end else begin
            m_total = tot;
            m_cnt   = 0;
            m_busy  = 1'b1;
         end
      end else if (m_busy && old_ov) begin
         m_cnt++;
         if (m_cnt == m_total) begin
            m_done = 1'b1;
            m_busy = 1'b0;
         end
      end
      m_err  = st ? 1'b0 : (m_err | ((av != '0) && (av != '1)));
      m_ov   = &av;
      m_dout = ad;
   endtask

   task automatic apply(input bit launch, input logic [W-1:0] row,
                        input logic [LANES-1:0] drop, input bit st, input int tot);
      for (int j = LANES-1; j > 0; j--) begin
         g_l[j] = g_l[j-1];
         g_d[j] = g_d[j-1];
         g_m[j] = g_m[j-1];
      end
      g_l[0] = launch;
      g_d[0] = row;
      g_m[0] = drop;
      for (int k = 0; k < LANES; k++) begin
         in_valid[k] = g_l[k] & ~g_m[k][k];
         data_in[(LANES-k)*DW-1 -: DW] = in_valid[k] ? g_d[k][(LANES-k)*DW-1 -: DW]
                                                    : DW'($urandom);
      end
      start     = st;
      row_total = CW'(tot);
      @(posedge clk);
      model_edge(st, tot);
      #1 check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply(1'b0, '0, '0, 1'b0, 0);
   endtask

   task automatic do_reset(input int cycles);
      in_valid = '0; data_in = '0; start = 1'b0; row_total = '0;
      #2 rst = 1'b1;
      #1;
      chk("rst_data_out",  64'(data_out),  64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_done",      64'(done),      64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_skew_err",  64'(skew_err),  64'd0);
      chk("rst_row_count", 64'(row_count), 64'd0);
      for (int j = 0; j < LANES; j++) begin
         h_v[j] = '0; h_d[j] = '0;
         g_l[j] = 1'b0; g_d[j] = '0; g_m[j] = '0;
      end
      m_ov = 0; m_done = 0; m_busy = 0; m_err = 0; m_dout = '0; m_cnt = 0; m_total = 0;
      repeat (cycles) @(posedge clk);
      #1 chk("rst_hold_valid", 64'(out_valid), 64'd0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      do_reset(2);

      // Single aligned row.
      apply(1'b1, 32'h11223344, '0, 1'b0, 0);
      idle(3);
      chk("row1_valid", 64'(out_valid), 64'd1);
      chk("row1_data",  64'(data_out),  64'h11223344);
      idle(1);
      chk("row1_single", 64'(out_valid), 64'd0);

      // Streaming three rows with counting.
      apply(1'b0, '0, '0, 1'b1, 3);
      chk("stream_busy", 64'(busy), 64'd1);
      apply(1'b1, 32'h01010101, '0, 1'b0, 0);
      apply(1'b1, 32'h02020202, '0, 1'b0, 0);
      apply(1'b1, 32'h03030303, '0, 1'b0, 0);
      n_done = 0;
      idle(6);
      chk("stream_done_cnt", 64'(n_done), 64'd1);
      chk("stream_count",    64'(row_count), 64'd3);
      chk("stream_idle",     64'(busy), 64'd0);

      // Misaligned row with lane2 dropped.
      apply(1'b1, 32'hA1B2C3D4, 4'b0100, 1'b0, 0);
      idle(6);
      chk("mis_sticky", 64'(skew_err), 64'd1);
      apply(1'b0, '0, '0, 1'b1, 0);
      chk("mis_cleared", 64'(skew_err), 64'd0);
      chk("zero_done",   64'(done), 64'd1);
      chk("zero_busy",   64'(busy), 64'd0);

      // Restart after one row of two.
      apply(1'b0, '0, '0, 1'b1, 2);
      apply(1'b1, 32'h5A5A5A5A, '0, 1'b0, 0);
      idle(4);
      chk("restart_pre", 64'(row_count), 64'd1);
      apply(1'b0, '0, '0, 1'b1, 2);
      chk("restart_zero", 64'(row_count), 64'd0);
      n_done = 0;
      apply(1'b1, 32'h10203040, '0, 1'b0, 0);
      apply(1'b1, 32'h50607080, '0, 1'b0, 0);
      idle(6);
      chk("restart_done_cnt", 64'(n_done), 64'd1);
      chk("restart_count",    64'(row_count), 64'd2);

      // Reset with a row half in flight.
      apply(1'b1, 32'hDEADBEEF, '0, 1'b0, 0);
      apply(1'b0, '0, '0, 1'b0, 0);
      do_reset(2);
      apply(1'b1, 32'hAABBCCDD, '0, 1'b0, 0);
      idle(3);
      chk("post_rst_valid", 64'(out_valid), 64'd1);
      chk("post_rst_data",  64'(data_out),  64'hAABBCCDD);
      idle(2);

      // Randomized traffic.
      for (int c = 0; c < 600; c++) begin
         logic [LANES-1:0] drop;
         drop = ($urandom_range(0, 15) == 0) ? LANES'(1 << $urandom_range(0, LANES-1)) : '0;
         apply($urandom_range(0, 3) != 0, W'($urandom), drop,
               $urandom_range(0, 25) == 0, int'($urandom_range(0, 6)));
      end
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
